fifo_rd_chk: RTL

- Read-side stage placed directly downstream of the FIFO write stage.
- Waits until the FIFO reports full, then drains it until almost-empty.
- Checks that the words read back form the writer's incrementing pattern: 0,1,…,MAX_VAL,0,…
- Exposes the read data, a sticky error flag and error/word counters for ILA/LED debug.

---
 rtl/fifo_rd_chk_if.sv | 19 +
 rtl/fifo_rd_chk.sv | 99 +++++++++
 2 files changed

// File: rtl/fifo_rd_chk_if.sv
// FIFO read-port bundle between the read-side checker (master) and the FIFO (slave).
interface fifo_rd_chk_if #(parameter int DATA_W = 8);
    logic              rd_rst_busy;
    logic              full;
    logic              almost_empty;
    logic              empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;

    modport master (
        input  rd_rst_busy, full, almost_empty, empty, fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output rd_rst_busy, full, almost_empty, empty, fifo_rd_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_rd_chk.sv
// Read-side stage: waits for FIFO full, drains to almost-empty and checks the
// words against the writer's wrapping incrementing pattern.
module fifo_rd_chk #(
    parameter int DATA_W  = 8,
    parameter int MAX_VAL = 254,
    parameter int CNT_W   = 16
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    fifo_rd_chk_if.master     fifo,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_data_vld,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic {IDLE, READ} state_t;

    state_t            state;
    logic              full_d0, full_d1;
    logic              rd_vld_int;
    logic              locked;
    logic [DATA_W-1:0] exp_val;

    function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] v);
        return (v >= DATA_W'(MAX_VAL)) ? '0 : v + DATA_W'(1);
    endfunction

    // full comes from the write clock domain
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            full_d0 <= 1'b0;
            full_d1 <= 1'b0;
        end else begin
            full_d0 <= fifo.full;
            full_d1 <= full_d0;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            fifo.fifo_rd_en <= 1'b0;
        end else if (fifo.rd_rst_busy) begin
            state           <= IDLE;
            fifo.fifo_rd_en <= 1'b0;
        end else begin
            case (state)
                IDLE: if (full_d1 && !fifo.empty) begin
                    state           <= READ;
                    fifo.fifo_rd_en <= 1'b1;
                end
                READ: if (fifo.almost_empty || fifo.empty) begin
                    // the read issued on this edge is covered by FIFO underflow protection
                    state           <= IDLE;
                    fifo.fifo_rd_en <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    fifo.fifo_rd_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_int  <= 1'b0;
            rd_data_out <= '0;
            rd_data_vld <= 1'b0;
            err_flag    <= 1'b0;
            err_cnt     <= '0;
            word_cnt    <= '0;
            locked      <= 1'b0;
            exp_val     <= '0;
        end else if (fifo.rd_rst_busy) begin
            rd_vld_int  <= 1'b0;
            rd_data_vld <= 1'b0;
            locked      <= 1'b0;
        end else begin
            rd_vld_int  <= fifo.fifo_rd_en && !fifo.empty;
            rd_data_vld <= rd_vld_int;
            if (rd_vld_int) begin
                rd_data_out <= fifo.fifo_rd_data;
                word_cnt    <= word_cnt + CNT_W'(1);
                exp_val     <= nxt(fifo.fifo_rd_data);
                locked      <= 1'b1;
                // exp_val never exceeds MAX_VAL, so out-of-range data always mismatches
                if (locked && (fifo.fifo_rd_data != exp_val)) begin
                    err_flag <= 1'b1;
                    if (err_cnt != {CNT_W{1'b1}})
                        err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
